div_issue: RTL

Issue and completion front-end for the 32-bit radix-4 SRT divider `div32`, sitting between the M-extension reservation station and the common data bus. It decodes DIV/DIVU/REM/REMU and resolves divide-by-zero and signed overflow locally, since `div32` does not handle them. All other operations go to `div32`; the block then returns quotient or remainder with its ROB tag over a valid/ready handshake. It also discards results of operations squashed by a pipeline flush while `div32` is still running, because `div32` cannot be aborted.

---
 rtl/div_issue_if.sv | 36 +++
 rtl/div_issue.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/div_issue_if.sv
// Issue/completion bus for div_issue: reservation-station side, CDB side and the div32 side.
interface div_issue_if #(parameter int TAG_W = 4);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [31:0]      in_a;
  logic [31:0]      in_b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic [TAG_W-1:0] out_tag;
  logic             div_in_en;
  logic [31:0]      div_a;
  logic [31:0]      div_b;
  logic             div_signed;
  logic             div_idle;
  logic             div_out_en;
  logic [31:0]      div_q;
  logic [31:0]      div_rem;

  modport slave (
    input  flush, in_valid, in_op, in_a, in_b, in_tag, out_ready,
           div_idle, div_out_en, div_q, div_rem,
    output in_ready, out_valid, out_data, out_tag,
           div_in_en, div_a, div_b, div_signed
  );

  modport master (
    output flush, in_valid, in_op, in_a, in_b, in_tag, out_ready,
           div_idle, div_out_en, div_q, div_rem,
    input  in_ready, out_valid, out_data, out_tag,
           div_in_en, div_a, div_b, div_signed
  );
endinterface

// File: rtl/div_issue.sv
// DIV/DIVU/REM/REMU issue front-end for div32: resolves x/0 and signed overflow locally,
// drains results of flushed divisions. Optional one-entry result cache: DIV_RESULT_CACHE_EN.
module div_issue #(
  parameter int TAG_W = 4
) (
  input logic        clk,
  input logic        rst,
  div_issue_if.slave bus
);
  localparam logic [31:0] INT_MIN = 32'h8000_0000;

  typedef enum logic [1:0] {IDLE, BUSY, DONE, DRAIN} state_e;

  state_e           state_q;
  logic [TAG_W-1:0] tag_q;
  logic             is_rem_q;
  logic             out_valid_q;
  logic [31:0]      out_data_q;
  logic             div_in_en_q;
  logic [31:0]      div_a_q;
  logic [31:0]      div_b_q;
  logic             div_signed_q;

  logic             rdy;
  logic             accept;
  logic             by_zero;
  logic             sgn_ovf;
  logic             cache_hit;
  logic [31:0]      hit_data;

  // Architectural results for the two cases div32 cannot produce.
  function automatic logic [31:0] corner_result(input logic is_rem, input logic zero_div,
                                                input logic [31:0] a);
    if (zero_div) return is_rem ? a : 32'hFFFF_FFFF;
    return is_rem ? 32'h0 : INT_MIN;
  endfunction

  assign rdy     = (state_q == IDLE) && bus.div_idle && !bus.flush && !rst;
  assign accept  = bus.in_valid && rdy;
  assign by_zero = (bus.in_b == 32'h0);
  assign sgn_ovf = !bus.in_op[0] && (bus.in_a == INT_MIN) && (bus.in_b == 32'hFFFF_FFFF);

`ifdef DIV_RESULT_CACHE_EN
  logic [31:0] c_a_q;
  logic [31:0] c_b_q;
  logic [31:0] c_quo_q;
  logic [31:0] c_rem_q;
  logic        c_sgn_q;
  logic        c_vld_q;

  // Only divisions that complete into DONE are remembered; drained ones never are.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_vld_q <= 1'b0;
      c_sgn_q <= 1'b0;
      c_a_q   <= '0;
      c_b_q   <= '0;
      c_quo_q <= '0;
      c_rem_q <= '0;
    end else if (state_q == BUSY && bus.div_out_en && !bus.flush) begin
      c_vld_q <= 1'b1;
      c_sgn_q <= div_signed_q;
      c_a_q   <= div_a_q;
      c_b_q   <= div_b_q;
      c_quo_q <= bus.div_q;
      c_rem_q <= bus.div_rem;
    end
  end

  assign cache_hit = c_vld_q && (bus.in_a == c_a_q) && (bus.in_b == c_b_q)
                     && (!bus.in_op[0] == c_sgn_q);
  assign hit_data  = bus.in_op[1] ? c_rem_q : c_quo_q;
`else
  assign cache_hit = 1'b0;
  assign hit_data  = 32'h0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      tag_q        <= '0;
      is_rem_q     <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      div_in_en_q  <= 1'b0;
      div_a_q      <= '0;
      div_b_q      <= '0;
      div_signed_q <= 1'b0;
    end else begin
      div_in_en_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            tag_q    <= bus.in_tag;
            is_rem_q <= bus.in_op[1];
            if (by_zero || sgn_ovf) begin
              out_data_q  <= corner_result(bus.in_op[1], by_zero, bus.in_a);
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end else if (cache_hit) begin
              out_data_q  <= hit_data;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end else begin
              div_a_q      <= bus.in_a;
              div_b_q      <= bus.in_b;
              div_signed_q <= !bus.in_op[0];
              div_in_en_q  <= 1'b1;
              state_q      <= BUSY;
            end
          end
        end
        BUSY: begin
          // div32 cannot be aborted: a flush mid-division waits it out in DRAIN.
          if (bus.flush) begin
            state_q <= bus.div_out_en ? IDLE : DRAIN;
          end else if (bus.div_out_en) begin
            out_data_q  <= is_rem_q ? bus.div_rem : bus.div_q;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (bus.flush || bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        DRAIN: begin
          if (bus.div_out_en) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready   = rdy;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_tag    = tag_q;
  assign bus.div_in_en  = div_in_en_q;
  assign bus.div_a      = div_a_q;
  assign bus.div_b      = div_b_q;
  assign bus.div_signed = div_signed_q;
endmodule
